// File: rtl/deframe_qam16.sv
`default_nettype none
// ============================================================================
//  Module   : deframe_qam16
//  Purpose  : Receive-side frame extractor for the QAM16 collector word
//             stream. Hunts for a sync word, validates a length header
//             (upper half must be the ones' complement of the lower half),
//             forwards payload words with start/end markers and compares a
//             trailing XOR check word. No backpressure; arbitrary gaps
//             between words are tolerated up to an idle timeout.
//  Ports    : CLK, RST (async, active high)
//             valid_i / data_i[31:0]          - input word stream
//             valid_o / data_o[31:0]          - payload word (registered)
//             sof_o / eof_o                   - first / last payload word
//             done_o / chk_ok_o               - check word evaluated / result
//             err_o                           - header error or idle timeout
//             busy_o                          - not hunting for sync
//  Revision : 1.0  initial release
// ============================================================================
module deframe_qam16 #(
  parameter logic [31:0] SYNC_WORD = 32'h1ACF_FC1D,
  parameter int unsigned MAX_LEN   = 255,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid_i,
  input  logic [31:0] data_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        sof_o,
  output logic        eof_o,
  output logic        done_o,
  output logic        chk_ok_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam logic [15:0] c_max_len    = 16'(MAX_LEN);
  // A timeout fires on the idle cycle that would take the counter to
  // TIMEOUT, so compare against TIMEOUT-1 before incrementing.
  localparam logic [15:0] c_timeout_m1 = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt,   w_cnt_nxt;
  logic [15:0] r_idle,  w_idle_nxt;
  logic [31:0] r_acc,   w_acc_nxt;
  logic        r_first, w_first_nxt;

  logic        w_valid, w_sof, w_eof, w_done, w_chk, w_err;
  logic [31:0] w_data;

  logic [15:0] w_len;
  logic        w_hdr_ok;

  assign w_len = data_i[15:0];
  // The sync word itself is rejected as a header even if it happened to
  // satisfy the complement/length rule for some SYNC_WORD choice.
  assign w_hdr_ok = (data_i[31:16] == ~data_i[15:0]) &&
                    (w_len != 16'd0) &&
                    (w_len <= c_max_len) &&
                    (data_i != SYNC_WORD);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idle_nxt  = r_idle;
    w_acc_nxt   = r_acc;
    w_first_nxt = r_first;
    w_valid     = 1'b0;
    w_data      = data_o;
    w_sof       = 1'b0;
    w_eof       = 1'b0;
    w_done      = 1'b0;
    w_chk       = 1'b0;
    w_err       = 1'b0;

    case (r_state)
      S_HUNT: begin
        if (valid_i && (data_i == SYNC_WORD)) begin
          w_state_nxt = S_HEADER;
        end
      end
      S_HEADER: begin
        if (valid_i) begin
          if (w_hdr_ok) begin
            w_cnt_nxt   = w_len;
            w_acc_nxt   = 32'h0;
            w_first_nxt = 1'b1;
            w_state_nxt = S_PAYLOAD;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_HUNT;
          end
        end
      end
      S_PAYLOAD: begin
        if (valid_i) begin
          w_valid     = 1'b1;
          w_data      = data_i;
          w_sof       = r_first;
          w_eof       = (r_cnt == 16'd1);
          w_acc_nxt   = r_acc ^ data_i;
          w_cnt_nxt   = r_cnt - 16'd1;
          w_first_nxt = 1'b0;
          if (r_cnt == 16'd1) begin
            w_state_nxt = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (valid_i) begin
          w_done      = 1'b1;
          w_chk       = (data_i == r_acc);
          w_state_nxt = S_HUNT;
        end
      end
      default: begin
        w_state_nxt = S_HUNT;
      end
    endcase

    // Idle supervision inside a frame. A word arriving on the would-be
    // timeout cycle wins and is processed by the case above.
    if (valid_i || (r_state == S_HUNT)) begin
      w_idle_nxt = 16'd0;
    end else if (r_idle == c_timeout_m1) begin
      w_idle_nxt  = 16'd0;
      w_err       = 1'b1;
      w_state_nxt = S_HUNT;
    end else begin
      w_idle_nxt = r_idle + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_HUNT;
      r_cnt    <= 16'd0;
      r_idle   <= 16'd0;
      r_acc    <= 32'h0;
      r_first  <= 1'b0;
      valid_o  <= 1'b0;
      data_o   <= 32'h0;
      sof_o    <= 1'b0;
      eof_o    <= 1'b0;
      done_o   <= 1'b0;
      chk_ok_o <= 1'b0;
      err_o    <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idle   <= w_idle_nxt;
      r_acc    <= w_acc_nxt;
      r_first  <= w_first_nxt;
      valid_o  <= w_valid;
      data_o   <= w_data;
      sof_o    <= w_sof;
      eof_o    <= w_eof;
      done_o   <= w_done;
      chk_ok_o <= w_chk;
      err_o    <= w_err;
      busy_o   <= (w_state_nxt != S_HUNT);
    end
  end

endmodule
`default_nettype wire

// File: doc/deframe_qam16.md
# deframe_qam16

Receive-side frame extractor that consumes the 32-bit word stream produced by the QAM16 demapper/collector stage. It hunts for a sync word, validates a length header, forwards payload words with start/end markers, and checks a trailing XOR check word. There is no backpressure: it accepts a word on every cycle `valid_i` is high, and gaps of any length between words are allowed.

## Interface
- `SYNC_WORD`, default 32'h1ACF_FC1D: frame delimiter word.
- `MAX_LEN`, default 255: maximum payload length in words; legal range 1..65535.
- `TIMEOUT`, default 1024: maximum idle cycles between words inside a frame; legal range 2..65535.
- `CLK` input 1: system clock; all logic is on the rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `valid_i` input 1: `data_i` is valid this cycle.
- `data_i` input 32: word from the upstream collector.
- `valid_o` output 1: `data_o` holds a payload word (one-cycle pulse).
- `data_o` output 32: payload word.
- `sof_o` output 1: qualifies the first payload word of a frame; only high together with `valid_o`.
- `eof_o` output 1: qualifies the last payload word of a frame; only high together with `valid_o`.
- `done_o` output 1: one-cycle pulse when the check word has been evaluated.
- `chk_ok_o` output 1: check result; meaningful only while `done_o` is high, 0 otherwise.
- `err_o` output 1: one-cycle pulse on a header error or an idle timeout.
- `busy_o` output 1: high whenever the state is not HUNT.

## Operation
- **States:** HUNT, HEADER, PAYLOAD, CHECK.
- **HUNT:**
  - On `valid_i` with `data_i == SYNC_WORD`, go to HEADER.
  - Any other word is discarded.
- **HEADER:** on `valid_i`, decode `len = data_i[15:0]`. The header is valid when `data_i[31:16] == ~data_i[15:0]` and `1 <= len <= MAX_LEN`.
  - Valid header: load the word counter with `len`, clear the XOR accumulator, set first-word flag, go to PAYLOAD.
  - Invalid header: pulse `err_o`, go to HUNT. A header word equal to `SYNC_WORD` is also an invalid header; it does not re-arm HEADER.
- **PAYLOAD:** on each `valid_i`:
  - Register `data_i` to `data_o` and pulse `valid_o`.
  - `sof_o` is high on the first word; `eof_o` is high when the counter equals 1.
  - `acc <= acc ^ data_i`; the counter decrements.
  - After the word with counter == 1, go to CHECK. For `len == 1`, `sof_o` and `eof_o` are high together.
  - Sync words inside the payload are not searched for; they are passed through as data.
- **CHECK:** on `valid_i`, pulse `done_o`; `chk_ok_o = (data_i == acc)`. Go to HUNT.
- **Idle timeout:**
  - The idle counter clears on every `valid_i` and in HUNT.
  - In HEADER, PAYLOAD or CHECK it increments each cycle `valid_i` is low.
  - When it reaches `TIMEOUT` without `valid_i`, pulse `err_o` and go to HUNT. Payload already emitted is not retracted and no `eof_o` is generated.
  - If `valid_i` is high in the cycle the counter would reach `TIMEOUT`, the word is processed normally and no timeout occurs.
- **Widths:** length and word counters are 16 bits, idle counter is 16 bits, accumulator is 32 bits. Counters never wrap, because length is bounded by `MAX_LEN` and the idle counter by `TIMEOUT`.

## Timing
- Reset (async assert): state goes to HUNT. All outputs are 0, including `data_o` = 32'h0 and `busy_o` = 0. Counters and accumulator clear. A reset mid-frame discards the frame with no `err_o`.
- `valid_o`, `data_o`, `sof_o` and `eof_o` are registered: 1 cycle latency from the accepting `valid_i` edge.
- `done_o` and `chk_ok_o`: 1 cycle after the check word is accepted.
- `err_o`:
  - header error: 1 cycle after the header word;
  - timeout: the cycle after the idle counter reaches `TIMEOUT`.
- `busy_o` is registered from the state: it rises 1 cycle after the sync word and falls 1 cycle after the check word, header error or timeout.
- Back-to-back frames are supported: a sync word presented in the cycle after the check word is detected.
- `valid_o` is held at 0 outside PAYLOAD; `data_o` holds its last value while `valid_o` is 0.

## Test plan
- **Nominal frame:** words 1ACFFC1D, FFFC0003, 11111111, 22222222, 44444444, 77777777, each on consecutive cycles.
  - Required: three `valid_o` pulses with data 11111111/22222222/44444444.
  - `sof_o` is high on the first, `eof_o` on the third.
  - `done_o` pulses with `chk_ok_o` = 1.
- **Bad check:** same frame with trailer 77777776.
  - Required: payload is output unchanged, then `done_o` = 1 with `chk_ok_o` = 0.
- **Header errors:**
  - header 12340003 → `err_o` pulse, return to HUNT, no `valid_o`;
  - header FFFF0000 (len 0) → `err_o` pulse;
  - header with len 256 at `MAX_LEN` = 255 → `err_o` pulse.
- **Gapped input and timeout:** `TIMEOUT` = 8.
  - A 2-word frame with 7-cycle gaps between words completes with `chk_ok_o` = 1.
  - The same frame with an 8-cycle gap after the first payload word: `err_o` pulses, `busy_o` falls, and no `eof_o` or `done_o` is produced.
- **Hunt robustness:** garbage words, then a 1-word payload 1ACFFC1D used as data, then trailer 1ACFFC1D, then immediately a second valid frame.
  - Required: the payload is passed through with `sof_o` and `eof_o` both high, `chk_ok_o` = 1, and the second frame is decoded correctly.
- **Reset mid-PAYLOAD:** assert `RST` asynchronously between clock edges after the 2nd of 3 payload words.
  - Required: all outputs go to 0 immediately and no `err_o` or `done_o` pulses.
  - After release, a new nominal frame decodes correctly.
